// File: rtl/move_commit_controller.sv
// Purpose: debounces the place button, commits legal moves to the X/O boards, alternates players, detects win/draw.
// Latency: board/move_count update at the edge where press_evt is high; winner/game_over/current_player one edge later.
// Backpressure: none; presses arriving in EVAL or OVER are dropped, illegal presses pulse illegal_move for one cycle.
module move_commit_controller #(
  parameter int          SYNC_STAGES     = 2,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cell_idx,
  input  logic       place_btn,
  input  logic       new_game,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       current_player,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       illegal_move
);

  typedef enum logic [1:0] {PLAY = 2'd0, EVAL = 2'd1, OVER = 2'd2} state_t;

  // Button conditioning state
  logic [SYNC_STAGES-1:0] r_sync;
  logic [15:0]            r_db_cnt;
  logic                   r_db_full_q;
  logic                   w_synced;
  logic                   w_db_full;
  logic                   w_press_evt;

  // Game state (current and next)
  state_t     r_state, w_state_n;
  logic [8:0] r_board_x, w_board_x_n;
  logic [8:0] r_board_o, w_board_o_n;
  logic       r_player, w_player_n;
  logic [3:0] r_count, w_count_n;
  logic       r_over, w_over_n;
  logic [1:0] r_winner, w_winner_n;
  logic       r_illegal, w_illegal_n;

  logic [8:0] w_cell_mask;
  logic       w_legal;
  logic       w_win;

  // True when the given board holds any of the eight winning lines
  function automatic logic f_win(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  assign w_synced    = r_sync[SYNC_STAGES-1];
  assign w_db_full   = (r_db_cnt == DEBOUNCE_CYCLES);
  // One pulse on the first cycle the counter sits at the threshold; holding produces no more
  assign w_press_evt = w_db_full & ~r_db_full_q;

  // Out-of-range indices shift the bit off the top, giving an empty mask
  assign w_cell_mask = 9'd1 << cell_idx;
  assign w_legal     = (cell_idx <= 4'd8) && ((r_board_x | r_board_o) & w_cell_mask) == 9'd0;
  assign w_win       = f_win(r_player ? r_board_o : r_board_x);

  // Synchronize the raw button and run the saturating debounce counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_db_cnt    <= 16'd0;
      r_db_full_q <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], place_btn};
      r_db_full_q <= w_db_full;
      if (!w_synced)
        r_db_cnt <= 16'd0;
      else if (!w_db_full)
        r_db_cnt <= r_db_cnt + 16'd1;
    end
  end

  // Register FSM state and all game outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= PLAY;
      r_board_x <= 9'd0;
      r_board_o <= 9'd0;
      r_player  <= 1'b0;
      r_count   <= 4'd0;
      r_over    <= 1'b0;
      r_winner  <= 2'b00;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_board_x <= w_board_x_n;
      r_board_o <= w_board_o_n;
      r_player  <= w_player_n;
      r_count   <= w_count_n;
      r_over    <= w_over_n;
      r_winner  <= w_winner_n;
      r_illegal <= w_illegal_n;
    end
  end

  // Next-state: commit in PLAY, judge the mover in EVAL, freeze in OVER; new_game wins over everything
  always_comb begin
    w_state_n   = r_state;
    w_board_x_n = r_board_x;
    w_board_o_n = r_board_o;
    w_player_n  = r_player;
    w_count_n   = r_count;
    w_over_n    = r_over;
    w_winner_n  = r_winner;
    w_illegal_n = 1'b0;
    if (new_game) begin
      w_state_n   = PLAY;
      w_board_x_n = 9'd0;
      w_board_o_n = 9'd0;
      w_player_n  = 1'b0;
      w_count_n   = 4'd0;
      w_over_n    = 1'b0;
      w_winner_n  = 2'b00;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_press_evt) begin
            if (w_legal) begin
              if (r_player) w_board_o_n = r_board_o | w_cell_mask;
              else          w_board_x_n = r_board_x | w_cell_mask;
              w_count_n = r_count + 4'd1;
              w_state_n = EVAL;
            end else begin
              w_illegal_n = 1'b1;
            end
          end
        end
        EVAL: begin
          if (w_win) begin
            w_winner_n = r_player ? 2'b10 : 2'b01;
            w_over_n   = 1'b1;
            w_state_n  = OVER;
          end else if (r_count == 4'd9) begin
            w_winner_n = 2'b11;
            w_over_n   = 1'b1;
            w_state_n  = OVER;
          end else begin
            w_player_n = ~r_player;
            w_state_n  = PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  assign board_x        = r_board_x;
  assign board_o        = r_board_o;
  assign current_player = r_player;
  assign move_count     = r_count;
  assign game_over      = r_over;
  assign winner         = r_winner;
  assign illegal_move   = r_illegal;

endmodule

// File: tb/tb_move_commit_controller.sv
// Directed bench for move_commit_controller with a short debounce window.
// Table of press/new_game steps with expected board state, plus hand-written corner sequences.
// Checks bounce rejection, new_game/press collision and asynchronous reset.
module tb_move_commit_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] cell_idx;
  logic       place_btn;
  logic       new_game;
  logic [8:0] board_x;
  logic [8:0] board_o;
  logic       current_player;
  logic [3:0] move_count;
  logic       game_over;
  logic [1:0] winner;
  logic       illegal_move;

  int checks = 0;
  int failures = 0;

  move_commit_controller #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .cell_idx(cell_idx), .place_btn(place_btn),
    .new_game(new_game), .board_x(board_x), .board_o(board_o),
    .current_player(current_player), .move_count(move_count),
    .game_over(game_over), .winner(winner), .illegal_move(illegal_move)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_new_game;
    logic [3:0] idx;
    logic [8:0] x;
    logic [8:0] o;
    logic       player;
    logic [3:0] count;
    logic [1:0] win;
    logic       over;
    int         pulses;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [8:0] x, input logic [8:0] o,
                           input logic p, input logic [3:0] c, input logic [1:0] w, input logic ov);
    chk({tag, " board_x"}, int'(board_x), int'(x));
    chk({tag, " board_o"}, int'(board_o), int'(o));
    chk({tag, " current_player"}, int'(current_player), int'(p));
    chk({tag, " move_count"}, int'(move_count), int'(c));
    chk({tag, " winner"}, int'(winner), int'(w));
    chk({tag, " game_over"}, int'(game_over), int'(ov));
  endtask

  // Hold the button long enough for one accepted press, release, let the counter clear
  task automatic do_press(input logic [3:0] idx, output int pulses);
    pulses = 0;
    @(negedge clk);
    cell_idx  = idx;
    place_btn = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (illegal_move) pulses++;
    end
    place_btn = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (illegal_move) pulses++;
    end
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    @(negedge clk);
  endtask

  task automatic add(input bit ng, input logic [3:0] idx, input logic [8:0] x, input logic [8:0] o,
                     input logic p, input logic [3:0] c, input logic [1:0] w, input logic ov, input int pl);
    vec_t v;
    v.is_new_game = ng; v.idx = idx; v.x = x; v.o = o; v.player = p;
    v.count = c; v.win = w; v.over = ov; v.pulses = pl;
    vq.push_back(v);
  endtask

  initial begin
    int pulses;
    int ill_cnt;
    int commits;
    logic [3:0] prev_cnt;

    rst_n = 1'b0; cell_idx = 4'd0; place_btn = 1'b0; new_game = 1'b0;

    // Basic two-move game
    add(0, 4'd4, 9'h010, 9'h000, 1'b1, 4'd1, 2'b00, 1'b0, 0);
    add(0, 4'd0, 9'h010, 9'h001, 1'b0, 4'd2, 2'b00, 1'b0, 0);
    // Illegal: occupied cell, then off-board index
    add(0, 4'd4, 9'h010, 9'h001, 1'b0, 4'd2, 2'b00, 1'b0, 1);
    add(0, 4'd9, 9'h010, 9'h001, 1'b0, 4'd2, 2'b00, 1'b0, 1);
    add(1, 4'd0, 9'h000, 9'h000, 1'b0, 4'd0, 2'b00, 1'b0, 0);
    // X wins on top row
    add(0, 4'd0, 9'h001, 9'h000, 1'b1, 4'd1, 2'b00, 1'b0, 0);
    add(0, 4'd3, 9'h001, 9'h008, 1'b0, 4'd2, 2'b00, 1'b0, 0);
    add(0, 4'd1, 9'h003, 9'h008, 1'b1, 4'd3, 2'b00, 1'b0, 0);
    add(0, 4'd4, 9'h003, 9'h018, 1'b0, 4'd4, 2'b00, 1'b0, 0);
    add(0, 4'd2, 9'h007, 9'h018, 1'b0, 4'd5, 2'b01, 1'b1, 0);
    // Press after game over is ignored, no illegal pulse
    add(0, 4'd8, 9'h007, 9'h018, 1'b0, 4'd5, 2'b01, 1'b1, 0);
    add(1, 4'd0, 9'h000, 9'h000, 1'b0, 4'd0, 2'b00, 1'b0, 0);
    // Draw game
    add(0, 4'd0, 9'h001, 9'h000, 1'b1, 4'd1, 2'b00, 1'b0, 0);
    add(0, 4'd1, 9'h001, 9'h002, 1'b0, 4'd2, 2'b00, 1'b0, 0);
    add(0, 4'd2, 9'h005, 9'h002, 1'b1, 4'd3, 2'b00, 1'b0, 0);
    add(0, 4'd4, 9'h005, 9'h012, 1'b0, 4'd4, 2'b00, 1'b0, 0);
    add(0, 4'd3, 9'h00D, 9'h012, 1'b1, 4'd5, 2'b00, 1'b0, 0);
    add(0, 4'd5, 9'h00D, 9'h032, 1'b0, 4'd6, 2'b00, 1'b0, 0);
    add(0, 4'd7, 9'h08D, 9'h032, 1'b1, 4'd7, 2'b00, 1'b0, 0);
    add(0, 4'd6, 9'h08D, 9'h072, 1'b0, 4'd8, 2'b00, 1'b0, 0);
    add(0, 4'd8, 9'h18D, 9'h072, 1'b0, 4'd9, 2'b11, 1'b1, 0);
    add(1, 4'd0, 9'h000, 9'h000, 1'b0, 4'd0, 2'b00, 1'b0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk_state("reset", 9'h000, 9'h000, 1'b0, 4'd0, 2'b00, 1'b0);
    chk("reset illegal_move", int'(illegal_move), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vq[i].is_new_game) begin
        do_new_game();
        pulses = 0;
      end else begin
        do_press(vq[i].idx, pulses);
      end
      chk_state(tag, vq[i].x, vq[i].o, vq[i].player, vq[i].count, vq[i].win, vq[i].over);
      chk({tag, " illegal pulses"}, pulses, vq[i].pulses);
    end

    // Bounce shorter than the debounce window, then a solid hold: exactly one commit
    cell_idx = 4'd4;
    commits = 0;
    prev_cnt = move_count;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (k < 2 || (k >= 4 && k < 6) || (k >= 10 && k < 30)) place_btn = 1'b1;
      else place_btn = 1'b0;
      if (move_count != prev_cnt) commits++;
      prev_cnt = move_count;
    end
    repeat (4) @(negedge clk);
    chk("bounce commits", commits, 1);
    chk_state("bounce", 9'h010, 9'h000, 1'b1, 4'd1, 2'b00, 1'b0);

    // new_game held across the cycle where the next press fires: press is swallowed
    cell_idx = 4'd0;
    ill_cnt = 0;
    @(negedge clk);
    place_btn = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      new_game = (k >= 3 && k < 9);
      if (illegal_move) ill_cnt++;
    end
    chk_state("newgame+press held", 9'h000, 9'h000, 1'b0, 4'd0, 2'b00, 1'b0);
    place_btn = 1'b0;
    repeat (6) @(negedge clk);
    chk_state("newgame+press released", 9'h000, 9'h000, 1'b0, 4'd0, 2'b00, 1'b0);
    chk("newgame illegal pulses", ill_cnt, 0);

    // Next press after the collision still works
    do_press(4'd8, pulses);
    chk_state("after newgame", 9'h100, 9'h000, 1'b1, 4'd1, 2'b00, 1'b0);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_state("async reset", 9'h000, 9'h000, 1'b0, 4'd0, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_press(4'd2, pulses);
    chk_state("post reset move", 9'h004, 9'h000, 1'b1, 4'd1, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_commit_controller.md
Name: move_commit_controller

Overview:
- Sits directly downstream of the switch-to-cell-index decoder.
- Consumes the 4-bit cell index (0-8 valid, 9 = off-board) plus a raw "place" pushbutton.
- Commits legal moves into the X/O board registers, alternates the player, and detects win/draw.
- Its board outputs drive the display/LED stage.

Parameters:
- SYNC_STAGES, 2, number of flops in the place_btn synchronizer (min 2).
- DEBOUNCE_CYCLES, 16'd50000, consecutive cycles the synchronized button must read high before a press is accepted (min 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cell_idx  input  4  cell index from the decoder; 0-8 = row-major cell (0 top-left, 8 bottom-right), 9-15 = invalid.
- place_btn  input  1  raw asynchronous pushbutton, active-high.
- new_game  input  1  synchronous clear request, level, active-high.
- board_x  output  9  bit i set = X occupies cell i.
- board_o  output  9  bit i set = O occupies cell i.
- current_player  output  1  0 = X to move, 1 = O to move.
- move_count  output  4  committed moves this game, 0-9.
- game_over  output  1  high once a win or draw is decided.
- winner  output  2  00 none, 01 X, 10 O, 11 draw.
- illegal_move  output  1  one-cycle pulse on a rejected press.

Behaviour:
- Reset (rst_n low, asynchronous): board_x = board_o = 0, current_player = 0, move_count = 0, game_over = 0, winner = 00, illegal_move = 0, FSM = PLAY, synchronizer/debounce/edge state cleared.
- Button path: SYNC_STAGES-flop synchronizer, then a debounce counter.
  - Counter increments while synced level = 1 and saturates at DEBOUNCE_CYCLES.
  - Counter clears to 0 whenever synced level = 0.
  - press_evt is a single-cycle internal pulse, high in the cycle the counter first reaches DEBOUNCE_CYCLES.
  - Holding the button yields exactly one press_evt. Release then re-press yields another.
- FSM states:
  - PLAY: on press_evt, cell_idx is sampled.
    - Legal (idx <= 8 and neither board bit set): set bit idx in board_x (player 0) or board_o (player 1), move_count += 1, go to EVAL.
    - Illegal (idx >= 9 or cell occupied): illegal_move = 1 for that one cycle, boards unchanged, stay in PLAY.
  - EVAL (exactly one cycle): test the board of the player who just moved against the 8 lines: rows {0,1,2},{3,4,5},{6,7,8}; columns {0,3,6},{1,4,7},{2,5,8}; diagonals {0,4,8},{2,4,6}.
    - Win: winner = 01 (X) / 10 (O), game_over = 1, current_player unchanged, go to OVER.
    - Else if move_count == 9: winner = 11, game_over = 1, go to OVER. A win on the 9th move takes precedence over draw.
    - Else: toggle current_player, go to PLAY.
  - OVER: press_evt ignored; illegal_move never pulses; all outputs held.
- Latency: board bit and move_count update at the edge where press_evt is high; winner/game_over/current_player update at the following edge (press_evt + 1).
- press_evt while in EVAL: dropped, no effect (it cannot occur in practice, since debounce min 1 plus edge spacing allow at most one press per hold).
- new_game, sampled high at an edge in any state:
  - Clears boards, move_count, winner, game_over, illegal_move; current_player = 0; FSM = PLAY.
  - Overrides a coincident press_evt.
  - The button debounce/edge state is not cleared, so a button held through new_game does not generate a press.
- Reset asserted mid-game: immediate return to the reset values, independent of clk.
- move_count never exceeds 9: OVER is always entered at the 9th move.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4; press cell 4, then cell 0 -> board_x=9'h010, board_o=9'h001, current_player=0, move_count=2, winner=00.
- X plays 0,1,2 while O plays 3,4 -> after the 5th press, at press_evt+1: winner=01, game_over=1, board_x=9'h007; a further press at idx 8 leaves all outputs unchanged and illegal_move stays 0.
- Press on occupied cell 4, then on idx 9 -> illegal_move pulses for one cycle each; boards, move_count and current_player unchanged.
- Sequence X:0,O:1,X:2,O:4,X:3,O:5,X:7,O:6,X:8 -> winner=11, game_over=1, move_count=9.
- Button bounce 1-0-1 shorter than DEBOUNCE_CYCLES, then held 20 cycles -> exactly one commit.
- Assert new_game in the same cycle as press_evt mid-game -> all outputs cleared, no bit set; assert rst_n low mid-cycle -> outputs clear asynchronously before the next clk edge.
